// File: rtl/sprite_move_scheduler.sv
// Per-frame movement sequencer: owns position and direction registers for all
// sprites and time-shares one maze legal-move query port, visiting sprites
// 0..NUM_SPRITES-1 once per frame_tick.
module sprite_move_scheduler #(
    parameter int                          NUM_SPRITES = 5,
    parameter logic [9:0]                  X_WRAP      = 10'd640,
    parameter logic [9:0]                  Y_MAX       = 10'd479,
    parameter logic [10*NUM_SPRITES-1:0]   INIT_X_FLAT = {NUM_SPRITES{10'd0}},
    parameter logic [10*NUM_SPRITES-1:0]   INIT_Y_FLAT = {NUM_SPRITES{10'd0}}
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_tick,
    input  logic [4*NUM_SPRITES-1:0]     req_dir_flat,
    input  logic [8*NUM_SPRITES-1:0]     speed_flat,
    output logic                         qry_req,
    output logic [2:0]                   qry_id,
    output logic [9:0]                   qry_x,
    output logic [9:0]                   qry_y,
    input  logic                         qry_ack,
    input  logic [3:0]                   qry_legal,
    output logic [10*NUM_SPRITES-1:0]    pos_x_flat,
    output logic [10*NUM_SPRITES-1:0]    pos_y_flat,
    output logic [4*NUM_SPRITES-1:0]     cur_dir_flat,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         overrun
);

    typedef enum logic [1:0] {S_IDLE, S_QUERY, S_UPDATE, S_DONE} state_t;

    localparam logic [2:0]  LAST_ID  = 3'(NUM_SPRITES - 1);
    localparam logic [10:0] WRAP_EXT = {1'b0, X_WRAP};
    localparam logic [10:0] YMAX_EXT = {1'b0, Y_MAX};

    state_t      state_q, state_d;
    logic [2:0]  id_q, id_d;
    logic [3:0]  legal_q, legal_d;
    logic        overrun_q, overrun_d;

    logic [9:0]  pos_x_q [NUM_SPRITES];
    logic [9:0]  pos_y_q [NUM_SPRITES];
    logic [3:0]  dir_q   [NUM_SPRITES];

    logic [9:0]  sel_x, sel_y;
    logic [3:0]  sel_dir, sel_req, req_low;
    logic [7:0]  sel_spd;
    logic [3:0]  new_dir;
    logic [9:0]  new_x, new_y;
    logic [10:0] ax_sum;

    // Pick out the registers and inputs belonging to the sprite being serviced.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        sel_x   = '0;
        sel_y   = '0;
        sel_dir = '0;
        sel_req = '0;
        sel_spd = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (id_q == 3'(i)) begin
                sel_x   = pos_x_q[i];
                sel_y   = pos_y_q[i];
                sel_dir = dir_q[i];
                sel_req = req_dir_flat[4*i +: 4];
                sel_spd = speed_flat[8*i +: 8];
            end
        end
    end

    // Resolve turn/keep/stop, then step along the one chosen axis with tunnel wrap or saturation.
    always_comb begin
        req_low = sel_req & (~sel_req + 4'd1);
        if ((req_low & legal_q) != 4'b0000) begin
            new_dir = req_low;
        end else if ((sel_dir & legal_q) != 4'b0000) begin
            new_dir = sel_dir;
        end else begin
            new_dir = 4'b0000;
        end

        new_x  = sel_x;
        new_y  = sel_y;
        ax_sum = '0;
        case (new_dir)
            4'b0001: begin
                if ({1'b0, sel_x} >= {3'b000, sel_spd}) ax_sum = {1'b0, sel_x} - {3'b000, sel_spd};
                else                                    ax_sum = {1'b0, sel_x} + WRAP_EXT - {3'b000, sel_spd};
                new_x = ax_sum[9:0];
            end
            4'b0010: begin
                ax_sum = {1'b0, sel_x} + {3'b000, sel_spd};
                if (ax_sum >= WRAP_EXT) ax_sum = ax_sum - WRAP_EXT;
                new_x = ax_sum[9:0];
            end
            4'b0100: begin
                if ({1'b0, sel_y} >= {3'b000, sel_spd}) ax_sum = {1'b0, sel_y} - {3'b000, sel_spd};
                else                                    ax_sum = '0;
                new_y = ax_sum[9:0];
            end
            4'b1000: begin
                ax_sum = {1'b0, sel_y} + {3'b000, sel_spd};
                if (ax_sum > YMAX_EXT) ax_sum = YMAX_EXT;
                new_y = ax_sum[9:0];
            end
            default: ;
        endcase
    end

    // FSM state and pass-control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            id_q      <= '0;
            legal_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            state_q   <= state_d;
            id_q      <= id_d;
            legal_q   <= legal_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state logic: walk the sprites one query/update pair at a time.
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        legal_d   = legal_q;
        overrun_d = overrun_q | (frame_tick & (state_q != S_IDLE));
        case (state_q)
            S_IDLE: begin
                if (frame_tick) begin
                    id_d    = '0;
                    state_d = S_QUERY;
                end
            end
            S_QUERY: begin
                if (qry_ack) begin
                    legal_d = qry_legal;
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                if (id_q == LAST_ID) begin
                    state_d = S_DONE;
                end else begin
                    id_d    = id_q + 3'd1;
                    state_d = S_QUERY;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the state; query fields read 0 outside QUERY.
    always_comb begin
        qry_req    = (state_q == S_QUERY);
        qry_id     = qry_req ? id_q  : 3'd0;
        qry_x      = qry_req ? sel_x : 10'd0;
        qry_y      = qry_req ? sel_y : 10'd0;
        busy       = (state_q != S_IDLE);
        frame_done = (state_q == S_DONE);
        overrun    = overrun_q;
    end

    // Per-sprite position/direction registers; only the serviced sprite is written, in UPDATE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: these arrays are architecturally visible state, so they are reset element by element (not a RAM).
            for (int i = 0; i < NUM_SPRITES; i++) begin
                pos_x_q[i] <= INIT_X_FLAT[10*i +: 10];
                pos_y_q[i] <= INIT_Y_FLAT[10*i +: 10];
                dir_q[i]   <= 4'b0000;
            end
        end else if (state_q == S_UPDATE) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (id_q == 3'(i)) begin
                    pos_x_q[i] <= new_x;
                    pos_y_q[i] <= new_y;
                    dir_q[i]   <= new_dir;
                end
            end
        end
    end

    // Flatten the register arrays onto the output buses.
    always_comb begin
        pos_x_flat   = '0;
        pos_y_flat   = '0;
        cur_dir_flat = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            pos_x_flat[10*i +: 10]  = pos_x_q[i];
            pos_y_flat[10*i +: 10]  = pos_y_q[i];
            cur_dir_flat[4*i +: 4]  = dir_q[i];
        end
    end

endmodule

// File: tb/tb_sprite_move_scheduler.sv
// Scoreboard bench for sprite_move_scheduler: stimulus pushes hand-computed
// end-of-pass state; a monitor compares it when frame_done pulses, and a query
// responder models the maze port (ack delay, legal masks, stability).
module tb_sprite_move_scheduler;

    localparam int N = 5;
    localparam logic [49:0] INIT_X = {10'd60,  10'd50, 10'd638, 10'd1,   10'd320};
    localparam logic [49:0] INIT_Y = {10'd477, 10'd2,  10'd200, 10'd100, 10'd240};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_tick = 1'b0;
    logic [19:0] req_dir_flat = '0;
    logic [39:0] speed_flat = '0;
    logic        qry_req;
    logic [2:0]  qry_id;
    logic [9:0]  qry_x, qry_y;
    logic        qry_ack = 1'b0;
    logic [3:0]  qry_legal = 4'b0000;
    logic [49:0] pos_x_flat, pos_y_flat;
    logic [19:0] cur_dir_flat;
    logic        busy, frame_done, overrun;

    sprite_move_scheduler #(
        .NUM_SPRITES (N),
        .X_WRAP      (10'd640),
        .Y_MAX       (10'd479),
        .INIT_X_FLAT (INIT_X),
        .INIT_Y_FLAT (INIT_Y)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .req_dir_flat (req_dir_flat),
        .speed_flat   (speed_flat),
        .qry_req      (qry_req),
        .qry_id       (qry_id),
        .qry_x        (qry_x),
        .qry_y        (qry_y),
        .qry_ack      (qry_ack),
        .qry_legal    (qry_legal),
        .pos_x_flat   (pos_x_flat),
        .pos_y_flat   (pos_y_flat),
        .cur_dir_flat (cur_dir_flat),
        .busy         (busy),
        .frame_done   (frame_done),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tick_cyc;
        int          lat;
        logic [49:0] x;
        logic [49:0] y;
        logic [19:0] d;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int wait_cnt    = 0;

    logic [9:0] ex_x [N];
    logic [9:0] ex_y [N];
    logic [3:0] ex_d [N];
    logic [3:0] req_a [N];
    logic [7:0] spd_a [N];
    logic [3:0] legal_a [8];
    int         ack_delay [8];
    logic [2:0] exp_qid, held_id;
    logic [9:0] exp_qx, exp_qy, held_x, held_y;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every frame_done must match the oldest expected pass.
    always @(negedge clk) begin
        if (!rst && frame_done) begin
            check("frame_done_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("pass_latency", 64'(cyc - mon_e.tick_cyc), 64'(mon_e.lat));
                check("pos_x_flat",   64'(pos_x_flat),   64'(mon_e.x));
                check("pos_y_flat",   64'(pos_y_flat),   64'(mon_e.y));
                check("cur_dir_flat", 64'(cur_dir_flat), 64'(mon_e.d));
            end
        end
    end

    // Maze query responder with programmable ack delay; checks the query is held stable while waiting.
    always @(negedge clk) begin
        if (qry_req) begin
            if (wait_cnt == 0) begin
                if (ack_delay[qry_id] != 0) begin
                    check("qry_id_value", 64'(qry_id), 64'(exp_qid));
                    check("qry_x_value",  64'(qry_x),  64'(exp_qx));
                    check("qry_y_value",  64'(qry_y),  64'(exp_qy));
                end
                held_id = qry_id;
                held_x  = qry_x;
                held_y  = qry_y;
            end else begin
                check("qry_id_stable", 64'(qry_id), 64'(held_id));
                check("qry_x_stable",  64'(qry_x),  64'(held_x));
                check("qry_y_stable",  64'(qry_y),  64'(held_y));
            end
            if (wait_cnt >= ack_delay[qry_id]) begin
                qry_ack   = 1'b1;
                qry_legal = legal_a[qry_id];
                wait_cnt  = 0;
            end else begin
                qry_ack   = 1'b0;
                qry_legal = ~legal_a[qry_id];
                wait_cnt++;
            end
        end else begin
            qry_ack   = 1'b0;
            qry_legal = 4'b0000;
            wait_cnt  = 0;
        end
    end

    task automatic defaults();
        for (int i = 0; i < N; i++) begin
            req_a[i]   = 4'b0000;
            spd_a[i]   = 8'd0;
            legal_a[i] = 4'b1111;
        end
        for (int i = 0; i < 8; i++) ack_delay[i] = 0;
    endtask

    task automatic set_s(input int i, input logic [3:0] req, input logic [7:0] spd, input logic [3:0] legal);
        req_a[i]   = req;
        spd_a[i]   = spd;
        legal_a[i] = legal;
    endtask

    task automatic exp_s(input int i, input logic [9:0] x, input logic [9:0] y, input logic [3:0] d);
        ex_x[i] = x;
        ex_y[i] = y;
        ex_d[i] = d;
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < N; i++) begin
            req_dir_flat[4*i +: 4] = req_a[i];
            speed_flat[8*i +: 8]   = spd_a[i];
        end
    endtask

    task automatic push_exp(input int lat);
        exp_t e;
        e.tick_cyc = cyc;
        e.lat      = lat;
        for (int i = 0; i < N; i++) begin
            e.x[10*i +: 10] = ex_x[i];
            e.y[10*i +: 10] = ex_y[i];
            e.d[4*i +: 4]   = ex_d[i];
        end
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("pass_finishes", 64'(busy), 64'd0);
    endtask

    task automatic run_frame(input int lat);
        @(negedge clk);
        apply_inputs();
        push_exp(lat);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        wait_idle();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pos_x"},  64'(pos_x_flat),   64'(INIT_X));
        check({tag, "_pos_y"},  64'(pos_y_flat),   64'(INIT_Y));
        check({tag, "_dir"},    64'(cur_dir_flat), 64'd0);
        check({tag, "_qry_req"}, 64'(qry_req),     64'd0);
        check({tag, "_qry_xy"}, 64'({qry_id, qry_x, qry_y}), 64'd0);
        check({tag, "_busy"},   64'(busy),         64'd0);
        check({tag, "_done"},   64'(frame_done),   64'd0);
        check({tag, "_overrun"}, 64'(overrun),     64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        defaults();
        apply_inputs();
        #2 rst = 1'b1;
        #1 check_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;

        // Frame 1: one move per sprite, covering both wraps and both saturations.
        defaults();
        set_s(0, 4'b0001, 8'd2, 4'b1111);
        set_s(1, 4'b0001, 8'd4, 4'b1111);
        set_s(2, 4'b0010, 8'd4, 4'b1111);
        set_s(3, 4'b0100, 8'd5, 4'b1111);
        set_s(4, 4'b1000, 8'd5, 4'b1111);
        exp_s(0, 10'd318, 10'd240, 4'b0001);
        exp_s(1, 10'd637, 10'd100, 4'b0001);
        exp_s(2, 10'd2,   10'd200, 4'b0010);
        exp_s(3, 10'd50,  10'd0,   4'b0100);
        exp_s(4, 10'd60,  10'd479, 4'b1000);
        run_frame(11);

        // Frame 2: sprite 0 turns right; sprite 1 turns with speed 0; sprite 4 stays saturated.
        defaults();
        set_s(0, 4'b0010, 8'd3, 4'b1111);
        set_s(1, 4'b0010, 8'd0, 4'b1111);
        set_s(4, 4'b1000, 8'd5, 4'b1111);
        exp_s(0, 10'd321, 10'd240, 4'b0010);
        exp_s(1, 10'd637, 10'd100, 4'b0010);
        run_frame(11);

        // Frame 3: illegal request keeps current direction; sprite 3 has neither legal and stops.
        defaults();
        set_s(0, 4'b0100, 8'd3, 4'b0010);
        set_s(3, 4'b0001, 8'd7, 4'b1000);
        exp_s(0, 10'd324, 10'd240, 4'b0010);
        exp_s(3, 10'd50,  10'd0,   4'b0000);
        run_frame(11);

        // Frame 4: nothing legal stops sprite 0 in place.
        defaults();
        set_s(0, 4'b0100, 8'd3, 4'b0000);
        exp_s(0, 10'd324, 10'd240, 4'b0000);
        run_frame(11);

        // Frame 5: multi-hot request resolves to its lowest legal index (up).
        defaults();
        set_s(0, 4'b1100, 8'd3, 4'b1100);
        exp_s(0, 10'd324, 10'd237, 4'b0100);
        run_frame(11);

        // Frame 6: sprite 2's query is acked 3 cycles late.
        defaults();
        set_s(2, 4'b0001, 8'd10, 4'b1111);
        ack_delay[2] = 3;
        exp_qid = 3'd2;
        exp_qx  = 10'd2;
        exp_qy  = 10'd200;
        exp_s(2, 10'd632, 10'd200, 4'b0001);
        run_frame(14);

        // Frame 7: extra ticks mid-pass and in the DONE cycle are ignored but flag overrun.
        check("overrun_before", 64'(overrun), 64'd0);
        defaults();
        set_s(0, 4'b1000, 8'd1, 4'b1111);
        exp_s(0, 10'd324, 10'd238, 4'b1000);
        @(negedge clk);
        apply_inputs();
        push_exp(11);
        k = cyc;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        while (cyc < k + 5) @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("overrun_set", 64'(overrun), 64'd1);
        while (cyc < k + 11) @(negedge clk);
        check("tick_in_done_cycle", 64'(frame_done), 64'd1);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("no_restart", 64'(busy), 64'd0);
        repeat (15) @(negedge clk);
        check("still_idle", 64'(busy), 64'd0);
        check("overrun_sticky", 64'(overrun), 64'd1);
        check("pos_x_single_pass", 64'(pos_x_flat[9:0]), 64'd324);
        check("pos_y_single_pass", 64'(pos_y_flat[9:0]), 64'd238);

        // Reset asserted while sprite 0's query is outstanding.
        defaults();
        ack_delay[0] = 50;
        exp_qid = 3'd0;
        exp_qx  = 10'd324;
        exp_qy  = 10'd238;
        @(negedge clk);
        apply_inputs();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        check("in_query_before_rst", 64'(qry_req), 64'd1);
        #2 rst = 1'b1;
        #1 check_reset_state("midrst");
        @(negedge clk);
        rst = 1'b0;
        ack_delay[0] = 0;
        repeat (3) @(negedge clk);
        check("idle_after_rst", 64'(busy), 64'd0);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
